// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing, coordinate width and sync bundle type.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_D = span_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
    localparam int V_TOTAL_D = span_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register; DEPTH=0 is a passthrough that still
// presents RST_VAL while reset is held.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = reset_n ? din : RST_VAL;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end
        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider, raster counters, sync/blank decode with a
// pixel-tick delay line, and frame/vblank strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_D,
    parameter int H_FP       = H_FP_D,
    parameter int H_SYNC     = H_SYNC_D,
    parameter int H_BP       = H_BP_D,
    parameter int V_ACTIVE   = V_ACTIVE_D,
    parameter int V_FP       = V_FP_D,
    parameter int V_SYNC     = V_SYNC_D,
    parameter int V_BP       = V_BP_D,
    parameter int PIX_DIV    = 2,
    parameter int SYNC_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               pix_en,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               video_on,
    output logic               vblank_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = $clog2(PIX_DIV);

    if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
    if (PIX_DIV < 2 || PIX_DIV > 8 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_cfg
        $error("vga_timing_gen: PIX_DIV must be 2..8 and SYNC_DELAY 0..4");
    end

    logic [DIV_W-1:0] div;
    logic             line_end;
    logic             last_line;
    sync_t            raw;
    sync_t            dly;

    assign line_end     = hpos == COORD_W'(H_TOTAL - 1);
    assign last_line    = vpos == COORD_W'(V_TOTAL - 1);
    assign vblank_start = pix_en && line_end && vpos == COORD_W'(V_ACTIVE - 1);
    assign frame_start  = pix_en && line_end && last_line;

    // pix_en is registered one clk ahead so it is high exactly while div == PIX_DIV-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div       <= '0;
            pix_en    <= 1'b0;
            hpos      <= '0;
            vpos      <= '0;
            frame_cnt <= '0;
        end else begin
            div    <= (div == DIV_W'(PIX_DIV - 1)) ? '0 : div + DIV_W'(1);
            pix_en <= div == DIV_W'(PIX_DIV - 2);
            if (pix_en) begin
                hpos <= line_end ? '0 : hpos + COORD_W'(1);
                if (line_end) vpos <= last_line ? '0 : vpos + COORD_W'(1);
                if (frame_start) frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign raw.hs  = !(int'(hpos) >= H_ACTIVE + H_FP && int'(hpos) < H_ACTIVE + H_FP + H_SYNC);
    assign raw.vs  = !(int'(vpos) >= V_ACTIVE + V_FP && int'(vpos) < V_ACTIVE + V_FP + V_SYNC);
    assign raw.act = int'(hpos) < H_ACTIVE && int'(vpos) < V_ACTIVE;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (SYNC_RST)
    ) u_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pix_en),
        .din     (raw),
        .dout    (dly)
    );

    assign hsync_n  = dly.hs;
    assign vsync_n  = dly.vs;
    assign video_on = dly.act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked every clk against a closed-form
// raster model driven only by the clk count since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       vb;
        logic       fs;
        logic [7:0] fc;
    } vs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_c_n = 1'b0;
    vs_t  oa, ob, oc;

    int     n_checks = 0;
    int     n_pass = 0;
    longint n_ab = 0;
    longint n_c = 0;
    longint cyc = 0;
    longint t_b656 = -1, t_bhs = -1, t_b640 = -1, t_bvid = -1;
    logic [9:0] prev_b_hpos = '0;
    logic       prev_b_hs = 1'b1;
    logic       prev_b_vid = 1'b0;
    logic [7:0] prev_c_fc = '0;
    bit         wrap_seen = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.PIX_DIV(2), .SYNC_DELAY(0)) u_a (
        .clk(clk), .reset_n(rst_n), .pix_en(oa.pix_en), .hpos(oa.hpos), .vpos(oa.vpos),
        .hsync_n(oa.hs), .vsync_n(oa.vs), .video_on(oa.vid), .vblank_start(oa.vb),
        .frame_start(oa.fs), .frame_cnt(oa.fc));

    vga_timing_gen #(.PIX_DIV(4), .SYNC_DELAY(3)) u_b (
        .clk(clk), .reset_n(rst_n), .pix_en(ob.pix_en), .hpos(ob.hpos), .vpos(ob.vpos),
        .hsync_n(ob.hs), .vsync_n(ob.vs), .video_on(ob.vid), .vblank_start(ob.vb),
        .frame_start(ob.fs), .frame_cnt(ob.fc));

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(2), .SYNC_DELAY(2)
    ) u_c (
        .clk(clk), .reset_n(rst_c_n), .pix_en(oc.pix_en), .hpos(oc.hpos), .vpos(oc.vpos),
        .hsync_n(oc.hs), .vsync_n(oc.vs), .video_on(oc.vid), .vblank_start(oc.vb),
        .frame_start(oc.fs), .frame_cnt(oc.fc));

    // Expected outputs n clks after reset release: tick = n / pd, position and frame
    // count follow from the tick by division; delayed outputs decode tick - sd.
    function automatic vs_t model(input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input int pd, input int sd, input bit rst, input longint n);
        longint ht, vt, t, d, h, v;
        vs_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (rst) return e;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        t = n / pd;
        h = t % ht;
        v = (t / ht) % vt;
        e.pix_en = (n % pd) == pd - 1;
        e.hpos = 10'(h);
        e.vpos = 10'(v);
        e.fc = 8'(t / (ht * vt));
        e.vb = e.pix_en && h == ht - 1 && v == va - 1;
        e.fs = e.pix_en && h == ht - 1 && v == vt - 1;
        if (t >= sd) begin
            d = t - sd;
            h = d % ht;
            v = (d / ht) % vt;
            e.hs = !(h >= ha + hf && h < ha + hf + hsw);
            e.vs = !(v >= va + vf && v < va + vf + vsw);
            e.vid = h < ha && v < va;
        end
        return e;
    endfunction

    function automatic vs_t exp_a();
        return model(640, 16, 96, 48, 480, 10, 2, 33, 2, 0, !rst_n, n_ab);
    endfunction
    function automatic vs_t exp_b();
        return model(640, 16, 96, 48, 480, 10, 2, 33, 4, 3, !rst_n, n_ab);
    endfunction
    function automatic vs_t exp_c();
        return model(6, 1, 2, 3, 4, 1, 2, 1, 2, 2, !rst_c_n, n_c);
    endfunction

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    task automatic check_all(input string dut, input vs_t got, input vs_t want);
        check({dut, ".pix_en"}, longint'(got.pix_en), longint'(want.pix_en));
        check({dut, ".hpos"}, longint'(got.hpos), longint'(want.hpos));
        check({dut, ".vpos"}, longint'(got.vpos), longint'(want.vpos));
        check({dut, ".hsync_n"}, longint'(got.hs), longint'(want.hs));
        check({dut, ".vsync_n"}, longint'(got.vs), longint'(want.vs));
        check({dut, ".video_on"}, longint'(got.vid), longint'(want.vid));
        check({dut, ".vblank_start"}, longint'(got.vb), longint'(want.vb));
        check({dut, ".frame_start"}, longint'(got.fs), longint'(want.fs));
        check({dut, ".frame_cnt"}, longint'(got.fc), longint'(want.fc));
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic step();
        @(posedge clk);
        n_ab = rst_n ? n_ab + 1 : 0;
        n_c = rst_c_n ? n_c + 1 : 0;
        @(negedge clk);
        cyc++;
        check_all("a", oa, exp_a());
        check_all("b", ob, exp_b());
        check_all("c", oc, exp_c());
        if (t_b656 < 0 && ob.hpos == 10'd656 && prev_b_hpos != 10'd656) t_b656 = cyc;
        if (t_b640 < 0 && ob.hpos == 10'd640 && prev_b_hpos != 10'd640) t_b640 = cyc;
        if (t_bhs < 0 && !ob.hs && prev_b_hs) t_bhs = cyc;
        if (t_bvid < 0 && !ob.vid && prev_b_vid) t_bvid = cyc;
        if (prev_c_fc == 8'd255 && oc.fc == 8'd0) wrap_seen = 1;
        prev_b_hpos = ob.hpos;
        prev_b_hs = ob.hs;
        prev_b_vid = ob.vid;
        prev_c_fc = oc.fc;
        if (n_checks - n_pass > 200) finish_run();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) step();
        rst_n = 1'b1;
        rst_c_n = 1'b1;
        step();
        check("a.first_pix_en", longint'(oa.pix_en), 1);
        check("a.hpos_hold", longint'(oa.hpos), 0);
        step();
        check("a.hpos_tick1", longint'(oa.hpos), 1);
        repeat (3300) step();
        check("b.hsync_lag_clks", t_bhs - t_b656, 12);
        check("b.video_lag_clks", t_bvid - t_b640, 12);

        // async reset in the middle of the small instance's vsync
        k = 0;
        while (!(oc.vpos == 10'd5 && oc.hpos == 10'd7) && k < 2000) begin
            step();
            k++;
        end
        check("c.reach_vsync", longint'(oc.vpos == 10'd5 && oc.hpos == 10'd7), 1);
        check("c.in_vsync", longint'(oc.vs), 0);
        #2 rst_c_n = 1'b0;
        #1;
        check_all("c_async", oc, model(6, 1, 2, 3, 4, 1, 2, 1, 2, 2, 1'b1, 0));
        repeat (2) step();
        rst_c_n = 1'b1;

        repeat (3) begin
            repeat ($urandom_range(20, 600)) step();
            #($urandom_range(1, 4)) rst_c_n = 1'b0;
            repeat ($urandom_range(1, 3)) step();
            rst_c_n = 1'b1;
        end

        repeat (257 * 96 * 2 + 50) step();
        check("c.frame_cnt_wrap", longint'(wrap_seen), 1);
        finish_run();
    end

endmodule
